kftvga_vram_arbiter: RTL and testbench

Single-clock arbiter and sequencer that shares one single-port 16-bit text VRAM (80x60 cells, 4800 words, byte enables, 1-cycle read latency) between three requesters: the video fetch unit, the 8-bit CPU bus, and an optional hardware screen-fill engine. It sits between the bus decoder and the VRAM macro on one side, and the text-mode video controller on the other. Video fetches always win the RAM; CPU accesses are handshaked so the bus can stall; the fill engine uses leftover cycles.

---
 rtl/kftvga_vram_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_kftvga_vram_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kftvga_vram_arbiter.sv
// kftvga_vram_arbiter
// Shares one single-port 16-bit text VRAM (1-cycle read latency, byte
// enables) between the video fetch unit, the 8-bit CPU bus and an optional
// screen-fill engine. Fixed per-cycle priority: video > CPU > fill.
// Optional feature macro: KFTVGA_VRAM_FILL_EN (fill engine present when
// defined; otherwise fill inputs are ignored and fill_busy is tied low).
//
// CPU handshake: cpu_write/cpu_read are sampled only in a cycle where
// cpu_ready=1 (write wins if both are high). cpu_ready then stays low until
// the access has completed; a read completes with a one-cycle cpu_read_valid
// pulse, and cpu_data_out holds that byte until the next read completes.
module kftvga_vram_arbiter #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW:0]   cpu_address,
  input  logic          cpu_write,
  input  logic          cpu_read,
  input  logic [7:0]    cpu_data_in,
  output logic          cpu_ready,
  output logic [7:0]    cpu_data_out,
  output logic          cpu_read_valid,
  input  logic          video_request,
  input  logic [AW-1:0] video_address,
  output logic [15:0]   video_data_out,
  output logic          video_data_valid,
  input  logic          fill_start,
  input  logic [15:0]   fill_data,
  output logic          fill_busy,
  output logic [AW-1:0] ram_address,
  output logic          ram_write,
  output logic [1:0]    ram_byte_enable,
  output logic [15:0]   ram_write_data,
  input  logic [15:0]   ram_read_data,
  output logic [1:0]    dbg_cpu_state,
  output logic          dbg_fill_state
);

  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    CPU_IDLE  = 2'd0,
    CPU_PEND  = 2'd1,
    CPU_RWAIT = 2'd2,
    CPU_RDONE = 2'd3
  } cpu_state_t;

  cpu_state_t    r_cpu_state;
  cpu_state_t    w_cpu_next;
  logic [AW-1:0] r_cpu_word;
  logic          r_cpu_hi;
  logic          r_cpu_is_write;
  logic          r_cpu_oor;
  logic [7:0]    r_cpu_wdata;
  logic [7:0]    r_cpu_rdata;
  logic          r_video_valid;

  logic          w_cpu_accept;
  logic          w_cpu_oor_in;
  logic          w_cpu_slot;
  logic          w_cpu_ram;
  logic          w_fill_grant;
  logic [AW-1:0] w_fill_addr;
  logic [15:0]   w_fill_word;

  assign w_cpu_accept = (r_cpu_state == CPU_IDLE) && (cpu_write || cpu_read);
  assign w_cpu_oor_in = (cpu_address[AW:1] > LAST_WORD);
  // The CPU gets its slot in any pending cycle without a video fetch; an
  // out-of-range access uses the slot for timing but never touches the RAM.
  assign w_cpu_slot   = (r_cpu_state == CPU_PEND) && !video_request;
  assign w_cpu_ram    = w_cpu_slot && !r_cpu_oor;

  // CPU FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_cpu_state <= CPU_IDLE;
    else          r_cpu_state <= w_cpu_next;
  end

  // CPU FSM next-state logic
  always_comb begin
    w_cpu_next = r_cpu_state;
    case (r_cpu_state)
      CPU_IDLE:  if (w_cpu_accept) w_cpu_next = CPU_PEND;
      CPU_PEND:  if (w_cpu_slot) w_cpu_next = r_cpu_is_write ? CPU_IDLE : CPU_RWAIT;
      CPU_RWAIT: w_cpu_next = CPU_RDONE;
      CPU_RDONE: w_cpu_next = CPU_IDLE;
      default:   w_cpu_next = CPU_IDLE;
    endcase
  end

  // Latch the accepted request and capture the read byte one cycle after the RAM read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_word     <= '0;
      r_cpu_hi       <= 1'b0;
      r_cpu_is_write <= 1'b0;
      r_cpu_oor      <= 1'b0;
      r_cpu_wdata    <= 8'h00;
      r_cpu_rdata    <= 8'h00;
    end else begin
      if (w_cpu_accept) begin
        r_cpu_word     <= cpu_address[AW:1];
        r_cpu_hi       <= cpu_address[0];
        r_cpu_is_write <= cpu_write;
        r_cpu_oor      <= w_cpu_oor_in;
        r_cpu_wdata    <= cpu_data_in;
      end
      if (r_cpu_state == CPU_RWAIT) begin
        if (r_cpu_oor)     r_cpu_rdata <= 8'h00;
        else if (r_cpu_hi) r_cpu_rdata <= ram_read_data[15:8];
        else               r_cpu_rdata <= ram_read_data[7:0];
      end
    end
  end

  // Video valid is the request delayed to line up with the RAM read latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_video_valid <= 1'b0;
    else          r_video_valid <= video_request;
  end

  assign cpu_ready        = (r_cpu_state == CPU_IDLE);
  assign cpu_read_valid   = (r_cpu_state == CPU_RDONE);
  assign cpu_data_out     = r_cpu_rdata;
  assign video_data_out   = ram_read_data;
  assign video_data_valid = r_video_valid;
  assign dbg_cpu_state    = r_cpu_state;

`ifdef KFTVGA_VRAM_FILL_EN
  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_t;

  fill_state_t   r_fill_state;
  fill_state_t   w_fill_next;
  logic [AW-1:0] r_fill_cnt;
  logic [15:0]   r_fill_data;

  // Fill only takes cycles that neither video nor a real CPU access uses
  assign w_fill_grant = (r_fill_state == FILL_RUN) && !video_request && !w_cpu_ram;

  // Fill FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_fill_state <= FILL_IDLE;
    else          r_fill_state <= w_fill_next;
  end

  // Fill FSM next-state logic: finish after the write of the last word
  always_comb begin
    w_fill_next = r_fill_state;
    case (r_fill_state)
      FILL_IDLE: if (fill_start) w_fill_next = FILL_RUN;
      FILL_RUN:  if (w_fill_grant && (r_fill_cnt == LAST_WORD)) w_fill_next = FILL_IDLE;
      default:   w_fill_next = FILL_IDLE;
    endcase
  end

  // Fill word/counter: loaded on start, advanced on each granted write, never wraps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_cnt  <= '0;
      r_fill_data <= 16'h0000;
    end else if ((r_fill_state == FILL_IDLE) && fill_start) begin
      r_fill_cnt  <= '0;
      r_fill_data <= fill_data;
    end else if (w_fill_grant && (r_fill_cnt != LAST_WORD)) begin
      r_fill_cnt  <= r_fill_cnt + 1'b1;
    end
  end

  assign w_fill_addr    = r_fill_cnt;
  assign w_fill_word    = r_fill_data;
  assign fill_busy      = (r_fill_state == FILL_RUN);
  assign dbg_fill_state = r_fill_state;
`else
  logic w_unused_fill;

  assign w_unused_fill  = ^{fill_start, fill_data};
  assign w_fill_grant   = 1'b0;
  assign w_fill_addr    = '0;
  assign w_fill_word    = 16'h0000;
  assign fill_busy      = 1'b0;
  assign dbg_fill_state = 1'b0;
`endif

  // RAM port driven from the cycle's winner; idle leaves everything at zero
  always_comb begin
    ram_address     = '0;
    ram_write       = 1'b0;
    ram_byte_enable = 2'b00;
    ram_write_data  = 16'h0000;
    if (video_request) begin
      ram_address = video_address;
    end else if (w_cpu_ram) begin
      ram_address = r_cpu_word;
      if (r_cpu_is_write) begin
        ram_write       = 1'b1;
        ram_byte_enable = r_cpu_hi ? 2'b10 : 2'b01;
        ram_write_data  = {r_cpu_wdata, r_cpu_wdata};
      end
    end else if (w_fill_grant) begin
      ram_address     = w_fill_addr;
      ram_write       = 1'b1;
      ram_byte_enable = 2'b11;
      ram_write_data  = w_fill_word;
    end
  end

endmodule

// File: tb/tb_kftvga_vram_arbiter.sv
// Directed testbench for kftvga_vram_arbiter with a behavioural VRAM model.
// Inputs change at the falling edge; outputs are sampled 1 ns later.
`timescale 1ns/1ps
module tb_kftvga_vram_arbiter;
  localparam int DEPTH = 4800;
  localparam int AW    = 13;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [AW:0]   cpu_address = '0;
  logic          cpu_write = 1'b0;
  logic          cpu_read = 1'b0;
  logic [7:0]    cpu_data_in = 8'h00;
  logic          cpu_ready;
  logic [7:0]    cpu_data_out;
  logic          cpu_read_valid;
  logic          video_request = 1'b0;
  logic [AW-1:0] video_address = '0;
  logic [15:0]   video_data_out;
  logic          video_data_valid;
  logic          fill_start = 1'b0;
  logic [15:0]   fill_data = 16'h0000;
  logic          fill_busy;
  logic [AW-1:0] ram_address;
  logic          ram_write;
  logic [1:0]    ram_byte_enable;
  logic [15:0]   ram_write_data;
  logic [15:0]   ram_read_data = 16'h0000;
  logic [1:0]    dbg_cpu_state;
  logic          dbg_fill_state;

  int checks = 0;
  int errors = 0;

  kftvga_vram_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_data_in(cpu_data_in), .cpu_ready(cpu_ready), .cpu_data_out(cpu_data_out),
    .cpu_read_valid(cpu_read_valid),
    .video_request(video_request), .video_address(video_address),
    .video_data_out(video_data_out), .video_data_valid(video_data_valid),
    .fill_start(fill_start), .fill_data(fill_data), .fill_busy(fill_busy),
    .ram_address(ram_address), .ram_write(ram_write), .ram_byte_enable(ram_byte_enable),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .dbg_cpu_state(dbg_cpu_state), .dbg_fill_state(dbg_fill_state)
  );

  // ---------------- VRAM model ----------------
  function automatic logic [15:0] init_word(input int i);
    return 16'(i) ^ 16'hC3A5;
  endfunction

  logic [15:0] mem [DEPTH];
  int wr_count = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
  end

  always @(posedge clock) begin
    if (ram_write) begin
      wr_count++;
      if (int'(ram_address) < DEPTH) begin
        if (ram_byte_enable[1]) mem[ram_address][15:8] = ram_write_data[15:8];
        if (ram_byte_enable[0]) mem[ram_address][7:0]  = ram_write_data[7:0];
      end
    end
    ram_read_data <= (int'(ram_address) < DEPTH) ? mem[ram_address] : 16'hDEAD;
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_read_valid !== 1'b0 || cpu_data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_cpu: ready=%b valid=%b data=%h, expected ready=1 valid=0 data=00",
               cpu_ready, cpu_read_valid, cpu_data_out);
    end
    checks++;
    if (video_data_valid !== 1'b0 || fill_busy !== 1'b0 || dbg_cpu_state !== 2'd0 || dbg_fill_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_misc: vvalid=%b busy=%b cpu_st=%0d fill_st=%b, expected 0 0 0 0",
               video_data_valid, fill_busy, dbg_cpu_state, dbg_fill_state);
    end
    checks++;
    if (ram_address !== '0 || ram_write !== 1'b0 || ram_byte_enable !== 2'b00 || ram_write_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_ram: addr=%h we=%b be=%b wd=%h, expected all 0",
               ram_address, ram_write, ram_byte_enable, ram_write_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Accept in N, check the RAM cycle in N+1 and cpu_ready in N+2.
  task automatic test_cpu_write(input logic [AW:0] addr, input logic [7:0] data, input logic in_range);
    logic [AW-1:0] exp_word;
    int wr_before;
    exp_word = addr[AW:1];
    @(negedge clock);
    cpu_address = addr; cpu_data_in = data; cpu_write = 1'b1;
    #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++; $display("FAIL wr_accept_ready addr=%h: got %b expected 1", addr, cpu_ready);
    end
    wr_before = wr_count;
    @(negedge clock);
    cpu_write = 1'b0;
    #1;
    checks++;
    if (in_range) begin
      if (ram_write !== 1'b1 || ram_address !== exp_word || ram_write_data !== {data, data} ||
          ram_byte_enable !== (addr[0] ? 2'b10 : 2'b01) || cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL wr_ram addr=%h: we=%b a=%h be=%b wd=%h rdy=%b, expected we=1 a=%h be=%b wd=%h rdy=0",
                 addr, ram_write, ram_address, ram_byte_enable, ram_write_data, cpu_ready,
                 exp_word, (addr[0] ? 2'b10 : 2'b01), {data, data});
      end
    end else begin
      if (ram_write !== 1'b0 || ram_address !== '0) begin
        errors++;
        $display("FAIL wr_oor_ram addr=%h: we=%b a=%h, expected we=0 a=0", addr, ram_write, ram_address);
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || ram_write !== 1'b0 || wr_count !== wr_before + (in_range ? 1 : 0)) begin
      errors++;
      $display("FAIL wr_done addr=%h: rdy=%b we=%b writes=%0d, expected rdy=1 we=0 writes=%0d",
               addr, cpu_ready, ram_write, wr_count - wr_before, (in_range ? 1 : 0));
    end
  endtask

  // Accept in N, RAM read in N+1, cpu_read_valid in N+3, cpu_ready in N+4.
  task automatic test_cpu_read(input logic [AW:0] addr, input logic [7:0] exp, input logic in_range);
    logic [AW-1:0] exp_word;
    exp_word = in_range ? addr[AW:1] : '0;
    @(negedge clock);
    cpu_address = addr; cpu_read = 1'b1;
    #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++; $display("FAIL rd_accept_ready addr=%h: got %b expected 1", addr, cpu_ready);
    end
    @(negedge clock);
    cpu_read = 1'b0;
    #1;
    checks++;
    if (ram_write !== 1'b0 || ram_address !== exp_word || cpu_ready !== 1'b0 || cpu_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_ram addr=%h: we=%b a=%h rdy=%b vld=%b, expected we=0 a=%h rdy=0 vld=0",
               addr, ram_write, ram_address, cpu_ready, cpu_read_valid, exp_word);
    end
    @(negedge clock);
    #1;
    checks++;
    if (cpu_read_valid !== 1'b0 || cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_n2 addr=%h: vld=%b rdy=%b, expected 0 0", addr, cpu_read_valid, cpu_ready);
    end
    @(negedge clock);
    #1;
    checks++;
    if (cpu_read_valid !== 1'b1 || cpu_data_out !== exp) begin
      errors++;
      $display("FAIL rd_data addr=%h: vld=%b data=%h, expected vld=1 data=%h", addr, cpu_read_valid, cpu_data_out, exp);
    end
    @(negedge clock);
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_read_valid !== 1'b0 || cpu_data_out !== exp) begin
      errors++;
      $display("FAIL rd_done addr=%h: rdy=%b vld=%b data=%h, expected rdy=1 vld=0 data=%h",
               addr, cpu_ready, cpu_read_valid, cpu_data_out, exp);
    end
  endtask

  task automatic test_video_stream();
    logic [AW-1:0] addrs [4];
    logic [15:0]   exps [4];
    addrs[0] = 13'd5; addrs[1] = 13'd6; addrs[2] = 13'd7; addrs[3] = 13'h1400;
    exps[0] = 16'hC3A0; exps[1] = 16'hC3A3; exps[2] = 16'hC3A2; exps[3] = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i < 4) begin video_request = 1'b1; video_address = addrs[i]; end
      else video_request = 1'b0;
      #1;
      if (i < 4) begin
        checks++;
        if (ram_address !== addrs[i] || ram_write !== 1'b0) begin
          errors++;
          $display("FAIL video_addr[%0d]: a=%h we=%b, expected a=%h we=0", i, ram_address, ram_write, addrs[i]);
        end
      end
      if (i > 0) begin
        checks++;
        if (video_data_valid !== 1'b1 || video_data_out !== exps[i-1]) begin
          errors++;
          $display("FAIL video_data[%0d]: vld=%b d=%h, expected vld=1 d=%h", i - 1, video_data_valid, video_data_out, exps[i-1]);
        end
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (video_data_valid !== 1'b0) begin
      errors++; $display("FAIL video_valid_drop: got %b expected 0", video_data_valid);
    end
  endtask

  // Write to byte 0x21 accepted, then 5 cycles of video; write lands right after.
  task automatic test_video_stall();
    int bad;
    bad = 0;
    @(negedge clock);
    cpu_address = 14'h0021; cpu_data_in = 8'h99; cpu_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      cpu_write = 1'b0; video_request = 1'b1; video_address = 13'd3;
      #1;
      if (cpu_ready !== 1'b0 || ram_write !== 1'b0 || ram_address !== 13'd3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_hold: %0d bad cycles, expected 0 (rdy=0, no write, video address)", bad);
    end
    @(negedge clock);
    video_request = 1'b0;
    #1;
    checks++;
    if (ram_write !== 1'b1 || ram_address !== 13'h010 || ram_byte_enable !== 2'b10 || ram_write_data !== 16'h9999) begin
      errors++;
      $display("FAIL stall_write: we=%b a=%h be=%b wd=%h, expected we=1 a=010 be=10 wd=9999",
               ram_write, ram_address, ram_byte_enable, ram_write_data);
    end
    @(negedge clock);
    #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++; $display("FAIL stall_ready: got %b expected 1", cpu_ready);
    end
  endtask

  task automatic test_simul_rw();
    int pulses;
    pulses = 0;
    @(negedge clock);
    cpu_address = 14'h0010; cpu_data_in = 8'h5A; cpu_write = 1'b1; cpu_read = 1'b1;
    @(negedge clock);
    cpu_write = 1'b0; cpu_read = 1'b0;
    #1;
    checks++;
    if (ram_write !== 1'b1 || ram_address !== 13'd8 || ram_byte_enable !== 2'b01 || ram_write_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL simul_write: we=%b a=%h be=%b wd=%h, expected we=1 a=008 be=01 wd=5a5a",
               ram_write, ram_address, ram_byte_enable, ram_write_data);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #1;
      if (cpu_read_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || cpu_ready !== 1'b1) begin
      errors++; $display("FAIL simul_no_read: valid pulses=%0d rdy=%b, expected 0 and 1", pulses, cpu_ready);
    end
  endtask

  // Reset asserted while a CPU read sits in RWAIT: access lost, no valid later.
  task automatic test_reset_mid_cpu();
    int pulses;
    pulses = 0;
    @(negedge clock);
    cpu_address = 14'h0001; cpu_read = 1'b1;
    @(negedge clock);
    cpu_read = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (dbg_cpu_state !== 2'd2) begin
      errors++; $display("FAIL midcpu_state: got %0d expected 2", dbg_cpu_state);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_data_out !== 8'h00 || cpu_read_valid !== 1'b0 || ram_write !== 1'b0) begin
      errors++;
      $display("FAIL midcpu_reset: rdy=%b data=%h vld=%b we=%b, expected 1 00 0 0",
               cpu_ready, cpu_data_out, cpu_read_valid, ram_write);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #1;
      if (cpu_read_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || cpu_ready !== 1'b1) begin
      errors++; $display("FAIL midcpu_lost: valid pulses=%0d rdy=%b, expected 0 and 1", pulses, cpu_ready);
    end
  endtask

`ifdef KFTVGA_VRAM_FILL_EN
  task automatic test_fill();
    int busy_cycles, writes, bad_wr, bad_mem;
    logic done;
    busy_cycles = 0; writes = 0; bad_wr = 0; bad_mem = 0; done = 1'b0;
    @(negedge clock);
    fill_data = 16'h0720; fill_start = 1'b1;
    #1;
    checks++;
    if (fill_busy !== 1'b0 || ram_write !== 1'b0) begin
      errors++; $display("FAIL fill_start_cycle: busy=%b we=%b, expected 0 0", fill_busy, ram_write);
    end
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clock);
      fill_start = (i == 2000);
      fill_data  = (i == 2000) ? 16'hFFFF : 16'h0000;
      #1;
      if (fill_busy === 1'b1) busy_cycles++;
      else done = 1'b1;
      if (ram_write === 1'b1) begin
        if (ram_address !== 13'(writes) || ram_write_data !== 16'h0720 || ram_byte_enable !== 2'b11) bad_wr++;
        writes++;
      end
    end
    fill_start = 1'b0;
    checks++;
    if (!done || busy_cycles != 4800) begin
      errors++; $display("FAIL fill_busy_len: busy %0d cycles done=%b, expected 4800 and 1", busy_cycles, done);
    end
    checks++;
    if (writes != 4800 || bad_wr != 0) begin
      errors++; $display("FAIL fill_writes: writes=%0d bad=%0d, expected 4800 and 0", writes, bad_wr);
    end
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 16'h0720) bad_mem++;
    checks++;
    if (bad_mem != 0) begin
      errors++; $display("FAIL fill_contents: %0d words differ, expected 0", bad_mem);
    end
  endtask

  // Reset lands in the cycle that would write word 100.
  task automatic test_fill_reset();
    int wr_before, stray;
    logic hit;
    hit = 1'b0; stray = 0;
    @(negedge clock);
    fill_data = 16'h1111; fill_start = 1'b1;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clock);
      fill_start = 1'b0;
      #1;
      if (ram_write === 1'b1 && ram_address === 13'd100) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL fillrst_reach: word 100 write not seen, expected within 300 cycles");
    end
    wr_before = wr_count;
    reset_n = 1'b0;
    #1;
    checks++;
    if (fill_busy !== 1'b0 || ram_write !== 1'b0 || ram_address !== '0 || cpu_ready !== 1'b1 || video_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL fillrst_outputs: busy=%b we=%b a=%h rdy=%b vvld=%b, expected 0 0 0 1 0",
               fill_busy, ram_write, ram_address, cpu_ready, video_data_valid);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      if (fill_busy !== 1'b0) stray++;
    end
    checks++;
    if (wr_count != wr_before || stray != 0) begin
      errors++; $display("FAIL fillrst_quiet: writes=%0d busy_cycles=%0d, expected 0 0", wr_count - wr_before, stray);
    end
    checks++;
    if (mem[99] !== 16'h1111 || mem[100] !== 16'h0720) begin
      errors++; $display("FAIL fillrst_mem: w99=%h w100=%h, expected 1111 0720", mem[99], mem[100]);
    end
  endtask
`else
  task automatic test_fill_disabled();
    int wr_before, stray;
    stray = 0;
    wr_before = wr_count;
    @(negedge clock);
    fill_data = 16'h1111; fill_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      fill_start = 1'b0;
      #1;
      if (fill_busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0 || wr_count != wr_before) begin
      errors++; $display("FAIL fill_disabled: busy_cycles=%0d writes=%0d, expected 0 0", stray, wr_count - wr_before);
    end
  endtask
`endif

  // ---------------- sequence & report ----------------
  initial begin
    test_reset();
    test_cpu_write(14'h0001, 8'h41, 1'b1);
    test_cpu_read(14'h0001, 8'h41, 1'b1);
    test_cpu_read(14'h0000, 8'hA5, 1'b1);
    test_video_stream();
    test_video_stall();
    test_simul_rw();
    test_cpu_read(14'h0010, 8'h5A, 1'b1);
    test_cpu_read(14'h0021, 8'h99, 1'b1);
    test_cpu_read(14'h2580, 8'h00, 1'b0);
    test_cpu_write(14'h2581, 8'h77, 1'b0);
    test_cpu_write(14'h257F, 8'hEE, 1'b1);
    test_cpu_read(14'h257E, 8'h1A, 1'b1);
    test_cpu_read(14'h257F, 8'hEE, 1'b1);
    test_reset_mid_cpu();
`ifdef KFTVGA_VRAM_FILL_EN
    test_fill();
    test_fill_reset();
`else
    test_fill_disabled();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
